csi2_pkt_parser: RTL and testbench

CSI2_PKT_PARSER -- requirements
Module: csi2_pkt_parser

---
 rtl/csi2_pkg.sv | 18 +
 rtl/csi2_pkt_parser_if.sv | 38 +++
 rtl/csi2_pkt_parser.sv | 246 ++++++++++++++++++++++++
 tb/tb_csi2_pkt_parser.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data-type codes and the packet parser FSM states.
package csi2_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    // Data types at or above this value are long packets
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        FOOTER  = 2'd2,
        DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/csi2_pkt_parser_if.sv
// Bundle of the packet parser's word input and its stream/event outputs.
interface csi2_pkt_parser_if;

    logic        valid_i;
    logic [31:0] data_i;
    logic        error_i;
    logic        error_corrected_i;
    logic        pkt_done_o;
    logic [31:0] tdata_o;
    logic        tvalid_o;
    logic [3:0]  tkeep_o;
    logic        tlast_o;
    logic        tuser_o;
    logic [5:0]  dt_o;
    logic [1:0]  vc_o;
    logic        fs_o;
    logic        fe_o;
    logic        ls_o;
    logic        le_o;
    logic [15:0] short_data_o;
    logic        hdr_err_o;
    logic        abort_o;

    // Word source side (ECC decoder) that also observes the parser outputs
    modport master (
        output valid_i, data_i, error_i, error_corrected_i,
        input  pkt_done_o, tdata_o, tvalid_o, tkeep_o, tlast_o, tuser_o,
        input  dt_o, vc_o, fs_o, fe_o, ls_o, le_o, short_data_o, hdr_err_o, abort_o
    );

    // Parser side
    modport slave (
        input  valid_i, data_i, error_i, error_corrected_i,
        output pkt_done_o, tdata_o, tvalid_o, tkeep_o, tlast_o, tuser_o,
        output dt_o, vc_o, fs_o, fe_o, ls_o, le_o, short_data_o, hdr_err_o, abort_o
    );

endinterface

// File: rtl/csi2_pkt_parser.sv
// CSI-2 packet parser: splits an ECC-decoded word stream into short-packet
// events and a byte-enabled payload stream, with VC filtering and timeout.
module csi2_pkt_parser
    import csi2_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [3:0] VC_MASK        = 4'b1111
) (
    input  logic        clk_i,
    input  logic        srst_i,
    input  logic        valid_i,
    input  logic [31:0] data_i,
    input  logic        error_i,
    input  logic        error_corrected_i,
    output logic        pkt_done_o,
    output logic [31:0] tdata_o,
    output logic        tvalid_o,
    output logic [3:0]  tkeep_o,
    output logic        tlast_o,
    output logic        tuser_o,
    output logic [5:0]  dt_o,
    output logic [1:0]  vc_o,
    output logic        fs_o,
    output logic        fe_o,
    output logic        ls_o,
    output logic        le_o,
    output logic [15:0] short_data_o,
    output logic        hdr_err_o,
    output logic        abort_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    // Header fields; the ECC byte has already been applied upstream
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_bad;
    logic        hdr_acc;
    logic        unused_ecc;

    assign hdr_vc     = data_i[7:6];
    assign hdr_dt     = data_i[5:0];
    assign hdr_wc     = data_i[23:8];
    assign hdr_bad    = error_i & ~error_corrected_i;
    assign hdr_acc    = VC_MASK[hdr_vc];
    assign unused_ecc = ^data_i[31:24];

    state_e        state_q, state_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          drop_q, drop_d;
    logic [3:0]    fs_seen_q, fs_seen_d;
    logic          pkt_done_q, pkt_done_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tvalid_q, tvalid_d;
    logic [3:0]    tkeep_q, tkeep_d;
    logic          tlast_q, tlast_d;
    logic          tuser_q, tuser_d;
    logic [5:0]    dt_q, dt_d;
    logic [1:0]    vc_q, vc_d;
    logic          fs_q, fs_d, fe_q, fe_d, ls_q, ls_d, le_q, le_d;
    logic [15:0]   short_data_q, short_data_d;
    logic          hdr_err_q, hdr_err_d;
    logic          abort_q, abort_d;

    // Next-state, counters and registered outputs
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        to_cnt_d     = to_cnt_q;
        drop_d       = drop_q;
        fs_seen_d    = fs_seen_q;
        pkt_done_d   = 1'b0;
        tdata_d      = '0;
        tvalid_d     = 1'b0;
        tkeep_d      = '0;
        tlast_d      = 1'b0;
        tuser_d      = 1'b0;
        dt_d         = dt_q;
        vc_d         = vc_q;
        fs_d         = 1'b0;
        fe_d         = 1'b0;
        ls_d         = 1'b0;
        le_d         = 1'b0;
        short_data_d = short_data_q;
        hdr_err_d    = 1'b0;
        abort_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    to_cnt_d = '0;
                    if (hdr_bad) begin
                        hdr_err_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        drop_d = ~hdr_acc;
                        if (hdr_acc) begin
                            dt_d = hdr_dt;
                            vc_d = hdr_vc;
                        end
                        if (hdr_dt < DT_LONG_MIN) begin
                            if (hdr_acc) begin
                                case (hdr_dt)
                                    DT_FS: begin
                                        fs_d              = 1'b1;
                                        fs_seen_d[hdr_vc] = 1'b1;
                                        short_data_d      = hdr_wc;
                                    end
                                    DT_FE: begin
                                        fe_d         = 1'b1;
                                        short_data_d = hdr_wc;
                                    end
                                    DT_LS: begin
                                        ls_d         = 1'b1;
                                        short_data_d = hdr_wc;
                                    end
                                    DT_LE: begin
                                        le_d         = 1'b1;
                                        short_data_d = hdr_wc;
                                    end
                                    default: ;
                                endcase
                            end
                            state_d = DONE;
                        end else begin
                            cnt_d   = hdr_wc;
                            state_d = (hdr_wc == 16'd0) ? FOOTER : PAYLOAD;
                        end
                    end
                end
            end

            PAYLOAD, FOOTER: begin
                if (valid_i) begin
                    to_cnt_d = '0;
                    if (state_q == FOOTER) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = (cnt_q > 16'd4) ? cnt_q - 16'd4 : 16'd0;
                        if (!drop_q) begin
                            tvalid_d         = 1'b1;
                            tdata_d          = data_i;
                            tlast_d          = (cnt_q <= 16'd4);
                            tuser_d          = fs_seen_q[vc_q];
                            fs_seen_d[vc_q]  = 1'b0;
                            case (cnt_q)
                                16'd1:   tkeep_d = 4'b0001;
                                16'd2:   tkeep_d = 4'b0011;
                                16'd3:   tkeep_d = 4'b0111;
                                default: tkeep_d = 4'b1111;
                            endcase
                        end
                        // A remainder of 3 or 0 bytes leaves the CRC in a further word
                        if (cnt_q <= 16'd4) begin
                            state_d = (cnt_q >= 16'd3) ? FOOTER : DONE;
                        end
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    to_cnt_d = '0;
                    state_d  = DONE;
                    if (!drop_q) begin
                        abort_d  = 1'b1;
                        tvalid_d = 1'b1;
                        tlast_d  = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end

            DONE: begin
                pkt_done_d = 1'b1;
                state_d    = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously on reset
    always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            to_cnt_q     <= '0;
            drop_q       <= 1'b0;
            fs_seen_q    <= '0;
            pkt_done_q   <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tkeep_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            dt_q         <= '0;
            vc_q         <= '0;
            fs_q         <= 1'b0;
            fe_q         <= 1'b0;
            ls_q         <= 1'b0;
            le_q         <= 1'b0;
            short_data_q <= '0;
            hdr_err_q    <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            to_cnt_q     <= to_cnt_d;
            drop_q       <= drop_d;
            fs_seen_q    <= fs_seen_d;
            pkt_done_q   <= pkt_done_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tkeep_q      <= tkeep_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            dt_q         <= dt_d;
            vc_q         <= vc_d;
            fs_q         <= fs_d;
            fe_q         <= fe_d;
            ls_q         <= ls_d;
            le_q         <= le_d;
            short_data_q <= short_data_d;
            hdr_err_q    <= hdr_err_d;
            abort_q      <= abort_d;
        end
    end

    assign pkt_done_o   = pkt_done_q;
    assign tdata_o      = tdata_q;
    assign tvalid_o     = tvalid_q;
    assign tkeep_o      = tkeep_q;
    assign tlast_o      = tlast_q;
    assign tuser_o      = tuser_q;
    assign dt_o         = dt_q;
    assign vc_o         = vc_q;
    assign fs_o         = fs_q;
    assign fe_o         = fe_q;
    assign ls_o         = ls_q;
    assign le_o         = le_q;
    assign short_data_o = short_data_q;
    assign hdr_err_o    = hdr_err_q;
    assign abort_o      = abort_q;

endmodule

// File: tb/tb_csi2_pkt_parser.sv
// Directed bench for csi2_pkt_parser (timeout shortened to 16, VC3 filtered).
module tb_csi2_pkt_parser;

    logic clk_i = 1'b0;
    logic srst_i;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    csi2_pkt_parser_if bus ();

    csi2_pkt_parser #(.TIMEOUT_CYCLES(16), .VC_MASK(4'b0111)) dut (
        .clk_i             (clk_i),
        .srst_i            (srst_i),
        .valid_i           (bus.valid_i),
        .data_i            (bus.data_i),
        .error_i           (bus.error_i),
        .error_corrected_i (bus.error_corrected_i),
        .pkt_done_o        (bus.pkt_done_o),
        .tdata_o           (bus.tdata_o),
        .tvalid_o          (bus.tvalid_o),
        .tkeep_o           (bus.tkeep_o),
        .tlast_o           (bus.tlast_o),
        .tuser_o           (bus.tuser_o),
        .dt_o              (bus.dt_o),
        .vc_o              (bus.vc_o),
        .fs_o              (bus.fs_o),
        .fe_o              (bus.fe_o),
        .ls_o              (bus.ls_o),
        .le_o              (bus.le_o),
        .short_data_o      (bus.short_data_o),
        .hdr_err_o         (bus.hdr_err_o),
        .abort_o           (bus.abort_o)
    );

    // Present one input word for one clock; outputs are read 1 ns after the edge
    task automatic drive(input logic v, input logic [31:0] d, input logic e, input logic ec);
        bus.valid_i           = v;
        bus.data_i            = d;
        bus.error_i           = e;
        bus.error_corrected_i = ec;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        srst_i = 1'b1;
        bus.valid_i = 1'b0; bus.data_i = '0; bus.error_i = 1'b0; bus.error_corrected_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if ({bus.tvalid_o, bus.tlast_o, bus.tkeep_o, bus.tdata_o} !== 38'd0) begin n_err++; $display("FAIL reset_stream: got %h want 0", {bus.tvalid_o, bus.tlast_o, bus.tkeep_o, bus.tdata_o}); end
        n_cmp++; if ({bus.pkt_done_o, bus.fs_o, bus.fe_o, bus.ls_o, bus.le_o, bus.hdr_err_o, bus.abort_o, bus.tuser_o} !== 8'd0) begin n_err++; $display("FAIL reset_pulses: got %b want 0", {bus.pkt_done_o, bus.fs_o, bus.fe_o, bus.ls_o, bus.le_o, bus.hdr_err_o, bus.abort_o, bus.tuser_o}); end
        n_cmp++; if ({bus.dt_o, bus.vc_o, bus.short_data_o} !== 24'd0) begin n_err++; $display("FAIL reset_fields: got %h want 0", {bus.dt_o, bus.vc_o, bus.short_data_o}); end
        srst_i = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (bus.pkt_done_o !== 1'b0) begin n_err++; $display("FAIL idle_done: got %b want 0", bus.pkt_done_o); end
    endtask

    task automatic test_frame_start();
        drive(1'b1, 32'h0000_0500, 1'b0, 1'b0);
        n_cmp++; if (bus.fs_o !== 1'b1) begin n_err++; $display("FAIL fs_pulse: got %b want 1", bus.fs_o); end
        n_cmp++; if (bus.short_data_o !== 16'd5) begin n_err++; $display("FAIL fs_short_data: got %h want 0005", bus.short_data_o); end
        n_cmp++; if (bus.vc_o !== 2'd0) begin n_err++; $display("FAIL fs_vc: got %h want 0", bus.vc_o); end
        n_cmp++; if (bus.pkt_done_o !== 1'b0) begin n_err++; $display("FAIL fs_done_early: got %b want 0", bus.pkt_done_o); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if ({bus.pkt_done_o, bus.fs_o} !== 2'b10) begin n_err++; $display("FAIL fs_done: got %b want 10", {bus.pkt_done_o, bus.fs_o}); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (bus.pkt_done_o !== 1'b0) begin n_err++; $display("FAIL fs_done_width: got %b want 0", bus.pkt_done_o); end
    endtask

    task automatic test_long_wc10();
        drive(1'b1, 32'h0000_0A2A, 1'b0, 1'b0);
        n_cmp++; if ({bus.tvalid_o, bus.dt_o} !== {1'b0, 6'h2A}) begin n_err++; $display("FAIL wc10_hdr: got %h want 2a", {bus.tvalid_o, bus.dt_o}); end
        drive(1'b1, 32'h1122_3344, 1'b0, 1'b0);
        n_cmp++; if ({bus.tvalid_o, bus.tdata_o, bus.tkeep_o, bus.tlast_o, bus.tuser_o} !== {1'b1, 32'h1122_3344, 4'b1111, 1'b0, 1'b1}) begin n_err++; $display("FAIL wc10_w0: got %h want %h", {bus.tvalid_o, bus.tdata_o, bus.tkeep_o, bus.tlast_o, bus.tuser_o}, {1'b1, 32'h1122_3344, 4'b1111, 1'b0, 1'b1}); end
        drive(1'b1, 32'h5566_7788, 1'b0, 1'b0);
        n_cmp++; if ({bus.tvalid_o, bus.tdata_o, bus.tkeep_o, bus.tlast_o, bus.tuser_o} !== {1'b1, 32'h5566_7788, 4'b1111, 1'b0, 1'b0}) begin n_err++; $display("FAIL wc10_w1: got %h want %h", {bus.tvalid_o, bus.tdata_o, bus.tkeep_o, bus.tlast_o, bus.tuser_o}, {1'b1, 32'h5566_7788, 4'b1111, 1'b0, 1'b0}); end
        drive(1'b1, 32'hCAFE_99AA, 1'b0, 1'b0);
        n_cmp++; if ({bus.tvalid_o, bus.tdata_o, bus.tkeep_o, bus.tlast_o} !== {1'b1, 32'hCAFE_99AA, 4'b0011, 1'b1}) begin n_err++; $display("FAIL wc10_w2: got %h want %h", {bus.tvalid_o, bus.tdata_o, bus.tkeep_o, bus.tlast_o}, {1'b1, 32'hCAFE_99AA, 4'b0011, 1'b1}); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if ({bus.pkt_done_o, bus.tvalid_o} !== 2'b10) begin n_err++; $display("FAIL wc10_done: got %b want 10", {bus.pkt_done_o, bus.tvalid_o}); end
    endtask

    task automatic test_long_wc8_footer();
        drive(1'b1, 32'h0000_086A, 1'b0, 1'b0);
        n_cmp++; if ({bus.dt_o, bus.vc_o} !== {6'h2A, 2'd1}) begin n_err++; $display("FAIL wc8_hdr: got %h want %h", {bus.dt_o, bus.vc_o}, {6'h2A, 2'd1}); end
        drive(1'b1, 32'hA0A1_A2A3, 1'b0, 1'b0);
        n_cmp++; if ({bus.tvalid_o, bus.tkeep_o, bus.tlast_o, bus.tuser_o} !== 7'b1_1111_0_0) begin n_err++; $display("FAIL wc8_w0: got %b want 1111100", {bus.tvalid_o, bus.tkeep_o, bus.tlast_o, bus.tuser_o}); end
        drive(1'b1, 32'hB0B1_B2B3, 1'b0, 1'b0);
        n_cmp++; if ({bus.tvalid_o, bus.tdata_o, bus.tkeep_o, bus.tlast_o} !== {1'b1, 32'hB0B1_B2B3, 4'b1111, 1'b1}) begin n_err++; $display("FAIL wc8_w1: got %h want %h", {bus.tvalid_o, bus.tdata_o, bus.tkeep_o, bus.tlast_o}, {1'b1, 32'hB0B1_B2B3, 4'b1111, 1'b1}); end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        n_cmp++; if ({bus.tvalid_o, bus.pkt_done_o} !== 2'b00) begin n_err++; $display("FAIL wc8_footer: got %b want 00", {bus.tvalid_o, bus.pkt_done_o}); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if ({bus.pkt_done_o, bus.tvalid_o} !== 2'b10) begin n_err++; $display("FAIL wc8_done: got %b want 10", {bus.pkt_done_o, bus.tvalid_o}); end
    endtask

    task automatic test_header_error();
        drive(1'b1, 32'h0000_0A2A, 1'b1, 1'b0);
        n_cmp++; if ({bus.hdr_err_o, bus.tvalid_o, bus.fs_o} !== 3'b100) begin n_err++; $display("FAIL hdr_err_pulse: got %b want 100", {bus.hdr_err_o, bus.tvalid_o, bus.fs_o}); end
        drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        n_cmp++; if ({bus.pkt_done_o, bus.hdr_err_o, bus.tvalid_o} !== 3'b100) begin n_err++; $display("FAIL hdr_err_done: got %b want 100", {bus.pkt_done_o, bus.hdr_err_o, bus.tvalid_o}); end
        // A corrected header is parsed normally
        drive(1'b1, 32'h0000_0701, 1'b1, 1'b1);
        n_cmp++; if ({bus.fe_o, bus.hdr_err_o, bus.short_data_o} !== {1'b1, 1'b0, 16'h0007}) begin n_err++; $display("FAIL hdr_corrected: got %h want %h", {bus.fe_o, bus.hdr_err_o, bus.short_data_o}, {1'b1, 1'b0, 16'h0007}); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        drive(1'b1, 32'h0000_0C2B, 1'b0, 1'b0);
        drive(1'b1, 32'h0102_0304, 1'b0, 1'b0);
        n_cmp++; if ({bus.tvalid_o, bus.tlast_o} !== 2'b10) begin n_err++; $display("FAIL to_w0: got %b want 10", {bus.tvalid_o, bus.tlast_o}); end
        for (int i = 1; i <= 15; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0);
            n_cmp++; if ({bus.abort_o, bus.tvalid_o} !== 2'b00) begin n_err++; $display("FAIL to_early_%0d: got %b want 00", i, {bus.abort_o, bus.tvalid_o}); end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if ({bus.abort_o, bus.tvalid_o, bus.tlast_o, bus.tkeep_o} !== 7'b111_0000) begin n_err++; $display("FAIL to_abort: got %b want 1110000", {bus.abort_o, bus.tvalid_o, bus.tlast_o, bus.tkeep_o}); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if ({bus.pkt_done_o, bus.abort_o} !== 2'b10) begin n_err++; $display("FAIL to_done: got %b want 10", {bus.pkt_done_o, bus.abort_o}); end
    endtask

    task automatic test_vc_filter();
        drive(1'b1, 32'h0000_09C0, 1'b0, 1'b0);
        n_cmp++; if ({bus.fs_o, bus.vc_o} !== {1'b0, 2'd0}) begin n_err++; $display("FAIL drop_fs: got %b want 000", {bus.fs_o, bus.vc_o}); end
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_04EA, 1'b0, 1'b0);
        drive(1'b1, 32'h7777_7777, 1'b0, 1'b0);
        n_cmp++; if (bus.tvalid_o !== 1'b0) begin n_err++; $display("FAIL drop_payload: got %b want 0", bus.tvalid_o); end
        drive(1'b1, 32'h8888_8888, 1'b0, 1'b0);
        n_cmp++; if (bus.tvalid_o !== 1'b0) begin n_err++; $display("FAIL drop_footer: got %b want 0", bus.tvalid_o); end
        drive(1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0382, 1'b0, 1'b0);
        n_cmp++; if ({bus.ls_o, bus.vc_o, bus.short_data_o} !== {1'b1, 2'd2, 16'h0003}) begin n_err++; $display("FAIL after_drop_ls: got %h want %h", {bus.ls_o, bus.vc_o, bus.short_data_o}, {1'b1, 2'd2, 16'h0003}); end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        drive(1'b1, 32'h0000_142A, 1'b0, 1'b0);
        drive(1'b1, 32'h4242_4242, 1'b0, 1'b0);
        n_cmp++; if (bus.tvalid_o !== 1'b1) begin n_err++; $display("FAIL rst_pre_word: got %b want 1", bus.tvalid_o); end
        srst_i = 1'b1;
        #1;
        n_cmp++; if ({bus.tvalid_o, bus.tdata_o, bus.dt_o, bus.vc_o, bus.pkt_done_o} !== 42'd0) begin n_err++; $display("FAIL rst_async_clear: got %h want 0", {bus.tvalid_o, bus.tdata_o, bus.dt_o, bus.vc_o, bus.pkt_done_o}); end
        bus.valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        srst_i = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (bus.pkt_done_o !== 1'b0) begin n_err++; $display("FAIL rst_no_done_a: got %b want 0", bus.pkt_done_o); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (bus.pkt_done_o !== 1'b0) begin n_err++; $display("FAIL rst_no_done_b: got %b want 0", bus.pkt_done_o); end
        drive(1'b1, 32'h0000_2141, 1'b0, 1'b0);
        n_cmp++; if ({bus.fe_o, bus.vc_o, bus.short_data_o} !== {1'b1, 2'd1, 16'h0021}) begin n_err++; $display("FAIL rst_next_hdr: got %h want %h", {bus.fe_o, bus.vc_o, bus.short_data_o}, {1'b1, 2'd1, 16'h0021}); end
        drive(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (bus.pkt_done_o !== 1'b1) begin n_err++; $display("FAIL rst_next_done: got %b want 1", bus.pkt_done_o); end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_long_wc10();
        test_long_wc8_footer();
        test_header_error();
        test_timeout();
        test_vc_filter();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
